// File: rtl/status_flag_unit.sv
// rtl/status_flag_unit.sv - ALU status flag register with save/restore stack and branch condition evaluator
module status_flag_unit #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 4,
  localparam int CW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] zbus,
  input  logic             carry_msb,
  input  logic             carry_msb_m1,
  input  logic             flag_load,
  input  logic [3:0]       flag_mask,
  input  logic             flag_wr,
  input  logic [3:0]       flag_wdata,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  input  logic [3:0]       cond,
  output logic [3:0]       flags,
  output logic             cond_true,
  output logic [CW-1:0]    stack_count,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  localparam logic [CW-1:0] DEPTH_C = CW'(STACK_DEPTH);

  // Sized to the full index range so stack_count addresses it without width conversion.
  logic [3:0] stack_mem [2**CW];

  logic [3:0] comp_flags;
  logic [3:0] next_flags;
  logic [3:0] stack_top;
  logic       push_ok;
  logic       pop_ok;
  logic       err_set;
  logic       z, v, s, c;

  assign comp_flags = {~|zbus, carry_msb ^ carry_msb_m1, zbus[WIDTH-1], carry_msb};

  assign stack_full  = (stack_count == DEPTH_C);
  assign stack_empty = (stack_count == '0);

  assign push_ok = push & ~pop & ~stack_full;
  assign pop_ok  = pop & ~push & ~stack_empty;
  assign err_set = (push & pop) | (push & ~pop & stack_full) | (pop & ~push & stack_empty);

  assign stack_top = stack_mem[stack_count - CW'(1)];

  always_comb begin
    next_flags = flags;
    if (pop_ok) begin
      next_flags = stack_top;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (flag_wr && flag_mask[i])
          next_flags[i] = flag_wdata[i];
        else if (flag_load && flag_mask[i])
          next_flags[i] = comp_flags[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags       <= 4'b0000;
      stack_count <= '0;
      stack_err   <= 1'b0;
    end else begin
      flags <= next_flags;
      if (push_ok)
        stack_count <= stack_count + CW'(1);
      else if (pop_ok)
        stack_count <= stack_count - CW'(1);
      // A new error event takes precedence over a simultaneous clear.
      if (err_set)
        stack_err <= 1'b1;
      else if (err_clr)
        stack_err <= 1'b0;
    end
  end

  // Saved flags are the pre-edge register value; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok)
      stack_mem[stack_count] <= flags;
  end

  assign {z, v, s, c} = flags;

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'd0:  cond_true = 1'b1;
      4'd1:  cond_true = z;
      4'd2:  cond_true = ~z;
      4'd3:  cond_true = c;
      4'd4:  cond_true = ~c;
      4'd5:  cond_true = s;
      4'd6:  cond_true = ~s;
      4'd7:  cond_true = v;
      4'd8:  cond_true = ~v;
      4'd9:  cond_true = c & ~z;
      4'd10: cond_true = ~c | z;
      4'd11: cond_true = (s == v);
      4'd12: cond_true = (s != v);
      4'd13: cond_true = ~z & (s == v);
      4'd14: cond_true = z | (s != v);
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_status_flag_unit.sv
// tb/tb_status_flag_unit.sv - scoreboard bench for status_flag_unit with a queue-based reference model
module tb_status_flag_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] zbus = '0;
  logic        carry_msb = 1'b0, carry_msb_m1 = 1'b0;
  logic        flag_load = 1'b0, flag_wr = 1'b0;
  logic [3:0]  flag_mask = '0, flag_wdata = '0;
  logic        push = 1'b0, pop = 1'b0, err_clr = 1'b0;
  logic [3:0]  cond = '0;
  logic [3:0]  flags;
  logic        cond_true;
  logic [2:0]  stack_count;
  logic        stack_full, stack_empty, stack_err;

  status_flag_unit #(.WIDTH(16), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .zbus(zbus), .carry_msb(carry_msb), .carry_msb_m1(carry_msb_m1),
    .flag_load(flag_load), .flag_mask(flag_mask), .flag_wr(flag_wr), .flag_wdata(flag_wdata),
    .push(push), .pop(pop), .err_clr(err_clr), .cond(cond), .flags(flags), .cond_true(cond_true),
    .stack_count(stack_count), .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] f;
    logic [2:0] cnt;
    logic       err;
    logic       ct;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_flags;
  logic [3:0] m_stack[$];
  logic       m_err;
  int         n_cmp = 0;
  int         n_fail = 0;

  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic zf, vf, sf, cf;
    {zf, vf, sf, cf} = f;
    case (c)
      4'd0:  return 1'b1;
      4'd1:  return zf;
      4'd2:  return !zf;
      4'd3:  return cf;
      4'd4:  return !cf;
      4'd5:  return sf;
      4'd6:  return !sf;
      4'd7:  return vf;
      4'd8:  return !vf;
      4'd9:  return cf && !zf;
      4'd10: return !cf || zf;
      4'd11: return sf == vf;
      4'd12: return sf != vf;
      4'd13: return !zf && (sf == vf);
      4'd14: return zf || (sf != vf);
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model's post-edge state goes to the scoreboard.
  task automatic cyc(input logic ld, input logic [3:0] mask, input logic wr, input logic [3:0] wd,
                     input logic psh, input logic pp, input logic clr,
                     input logic [15:0] zb, input logic cm, input logic cm1, input logic [3:0] cnd);
    logic [3:0] comp, old, top;
    logic       pop_valid, err_ev;
    exp_t       e;
    @(negedge clk);
    flag_load = ld; flag_mask = mask; flag_wr = wr; flag_wdata = wd;
    push = psh; pop = pp; err_clr = clr; zbus = zb; carry_msb = cm; carry_msb_m1 = cm1; cond = cnd;
    comp = {zb == 16'd0, cm ^ cm1, zb[15], cm};
    old = m_flags;
    pop_valid = pp && !psh && m_stack.size() > 0;
    err_ev = (psh && pp) || (psh && !pp && m_stack.size() == DEPTH) || (pp && !psh && m_stack.size() == 0);
    top = 4'b0;
    if (pop_valid) top = m_stack.pop_back();
    else if (psh && !pp && m_stack.size() < DEPTH) m_stack.push_back(old);
    if (pop_valid) m_flags = top;
    else
      for (int i = 0; i < 4; i++)
        if (wr && mask[i]) m_flags[i] = wd[i];
        else if (ld && mask[i]) m_flags[i] = comp[i];
    if (err_ev) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    e.f = m_flags; e.cnt = 3'(m_stack.size()); e.err = m_err; e.ct = ref_cond(cnd, m_flags);
    sb.push_back(e);
  endtask

  task automatic idle(input logic [3:0] cnd);
    cyc(0, 4'h0, 0, 4'h0, 0, 0, 0, 16'h1234, 0, 0, cnd);
  endtask

  task automatic setf(input logic [3:0] v);
    cyc(0, 4'hF, 1, v, 0, 0, 0, 16'h0, 0, 0, 4'd0);
  endtask

  // Monitor: compares one scoreboard entry after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("flags", 32'(flags), 32'(e.f));
        check("stack_count", 32'(stack_count), 32'(e.cnt));
        check("stack_full", 32'(stack_full), 32'(e.cnt == 3'(DEPTH)));
        check("stack_empty", 32'(stack_empty), 32'(e.cnt == 3'd0));
        check("stack_err", 32'(stack_err), 32'(e.err));
        check("cond_true", 32'(cond_true), 32'(e.ct));
      end
    end
  end

  initial begin
    logic [3:0] pats[5];
    pats[0] = 4'b0000; pats[1] = 4'b1000; pats[2] = 4'b0110; pats[3] = 4'b0011; pats[4] = 4'b1111;
    m_flags = 4'b0; m_err = 1'b0;
    #12;
    check("reset_flags", 32'(flags), 32'h0);
    check("reset_count", 32'(stack_count), 32'h0);
    check("reset_err", 32'(stack_err), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Computed flags, mask qualification and write-over-load priority.
    cyc(1, 4'hF, 0, 4'h0, 0, 0, 0, 16'h0000, 1, 0, 4'd1);
    idle(4'd11);
    cyc(1, 4'b0010, 0, 4'h0, 0, 0, 0, 16'h8000, 0, 0, 4'd0);
    cyc(1, 4'hF, 1, 4'h0, 0, 0, 0, 16'h8000, 1, 1, 4'd0);

    // Fill, overflow, drain in LIFO order, then an underflowing pop with a load.
    for (int i = 0; i < 4; i++) begin
      setf(4'(1 << i));
      cyc(0, 4'h0, 0, 4'h0, 1, 0, 0, 16'h0, 0, 0, 4'd0);
    end
    cyc(0, 4'h0, 0, 4'h0, 1, 0, 0, 16'h0, 0, 0, 4'd0);
    for (int i = 0; i < 4; i++) cyc(0, 4'h0, 0, 4'h0, 0, 1, 0, 16'h0, 0, 0, 4'd3);
    cyc(0, 4'h0, 0, 4'h0, 0, 0, 1, 16'h0, 0, 0, 4'd0);
    setf(4'b1010);
    cyc(1, 4'hF, 0, 4'h0, 0, 1, 0, 16'h0001, 0, 0, 4'd1);
    cyc(0, 4'h0, 0, 4'h0, 0, 0, 1, 16'h0, 0, 0, 4'd0);

    // Error set beats clear in the same cycle.
    cyc(0, 4'h0, 0, 4'h0, 0, 1, 1, 16'h0, 0, 0, 4'd0);
    cyc(0, 4'h0, 0, 4'h0, 0, 0, 1, 16'h0, 0, 0, 4'd0);

    // Count 2, simultaneous push+pop, then asynchronous reset between edges.
    setf(4'b0101); cyc(0, 4'h0, 0, 4'h0, 1, 0, 0, 16'h0, 0, 0, 4'd0);
    setf(4'b0110); cyc(0, 4'h0, 0, 4'h0, 1, 0, 0, 16'h0, 0, 0, 4'd0);
    setf(4'b1001);
    cyc(0, 4'h0, 0, 4'h0, 1, 1, 0, 16'h0, 0, 0, 4'd0);
    @(posedge clk);
    #2;
    flag_load = 0; flag_wr = 0; push = 0; pop = 0; err_clr = 0;
    reset = 1'b0;
    #1;
    check("async_flags", 32'(flags), 32'h0);
    check("async_count", 32'(stack_count), 32'h0);
    check("async_err", 32'(stack_err), 32'h0);
    m_flags = 4'b0; m_err = 1'b0; m_stack.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Condition sweep over selected flag patterns.
    for (int p = 0; p < 5; p++) begin
      setf(pats[p]);
      for (int c = 0; c < 16; c++) idle(4'(c));
    end

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] zb;
      zb = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      cyc($urandom_range(0, 1) == 1, 4'($urandom), $urandom_range(0, 3) == 0, 4'($urandom),
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
          zb, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 4'($urandom));
    end
    idle(4'd0);

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/status_flag_unit.md
Name: status_flag_unit

Overview:
- Parametrised successor of the ALU status detector and flag flip-flops.
- Derives Z/V/S/C from a WIDTH-bit result bus and stores them in a masked flag register.
- Provides a STACK_DEPTH-entry flag save/restore stack for interrupt entry/return, plus a branch condition evaluator.
- Sits between the ALU result bus (ZBUS) and the control unit's branch/interrupt sequencer.

Parameters:
- WIDTH, 16, result bus width; legal range is 2 or more.
- STACK_DEPTH, 4, number of flag save entries; legal range is 1 or more. The count width is clog2(STACK_DEPTH+1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- zbus  in  WIDTH  ALU result bus.
- carry_msb  in  1  carry out of bit WIDTH-1.
- carry_msb_m1  in  1  carry into bit WIDTH-1.
- flag_load  in  1  latch the computed flags, qualified by flag_mask.
- flag_mask  in  4  per-flag update enable, ordered {Z,V,S,C}.
- flag_wr  in  1  direct write of flag_wdata, qualified by flag_mask.
- flag_wdata  in  4  direct write data, ordered {Z,V,S,C}.
- push  in  1  save the current flags onto the stack.
- pop  in  1  restore flags from the top of the stack.
- err_clr  in  1  clear stack_err.
- cond  in  4  condition code select.
- flags  out  4  registered {Z,V,S,C}.
- cond_true  out  1  combinational result of the selected condition.
- stack_count  out  clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_full  out  1  asserted when stack_count equals STACK_DEPTH.
- stack_empty  out  1  asserted when stack_count equals 0.
- stack_err  out  1  sticky overflow/underflow indicator.

Behaviour:
- Computed flags (combinational):
  - Z = NOR of all zbus bits.
  - V = carry_msb XOR carry_msb_m1.
  - S = zbus[WIDTH-1].
  - C = carry_msb.
- Reset (reset low, asynchronous, any time including mid-push/pop):
  - flags = 0000, stack_count = 0, stack_err = 0.
  - Stack contents are don't-care.
  - The first rising edge after reset deasserts acts normally.
- Flag register update, for each bit i, priority order:
  1. A valid pop loads the stack top into all 4 bits; mask is ignored.
  2. Otherwise flag_wr with flag_mask[i]=1 loads flag_wdata[i].
  3. Otherwise flag_load with flag_mask[i]=1 loads the computed flag[i].
  4. Otherwise the bit holds.
- Latency: flags reflect an update 1 cycle after the enabling edge. cond_true follows flags combinationally, with zero added latency.
- Stack operation:
  - push alone, not full: stores the pre-edge registered flags at index stack_count, and stack_count increments. A flag update in the same cycle still applies; the pushed value is the old one.
  - push alone, full: push is discarded; stack_err is set and the count is unchanged.
  - pop alone, not empty: flags take entry [stack_count-1], and stack_count decrements.
  - pop alone, empty: flags are unchanged by the pop (lower-priority flag_wr/flag_load still apply); stack_err is set.
  - push and pop in the same cycle: no stack change, pop is treated as invalid, stack_err is set. flag_wr/flag_load still apply.
- stack_err:
  - Sticky; cleared by err_clr.
  - If a set event and err_clr occur in the same cycle, the set wins.
- stack_full and stack_empty are decoded combinationally from stack_count.
- cond map (flags = registered values):
  - 0: always 1.
  - 1 EQ: Z.
  - 2 NE: ~Z.
  - 3 CS: C.
  - 4 CC: ~C.
  - 5 MI: S.
  - 6 PL: ~S.
  - 7 VS: V.
  - 8 VC: ~V.
  - 9 HI: C & ~Z.
  - 10 LS: ~C | Z.
  - 11 GE: S==V.
  - 12 LT: S!=V.
  - 13 GT: ~Z & (S==V).
  - 14 LE: Z | (S!=V).
  - 15: never, 0.

Test Plan:
- Reset, then flag_load=1, mask=1111, zbus=0x0000, carry_msb=1, carry_msb_m1=0 -> next cycle flags=1101 (Z=1, V=1, S=0, C=1); cond=1 gives cond_true=1, cond=11 gives 0.
- flags=1101; flag_load with mask=0010, zbus=0x8000 -> flags=1111. Then flag_wr=1 and flag_load=1 same cycle, mask=1111, wdata=0000 -> flags=0000 (write wins).
- STACK_DEPTH=4: push 4 distinct values (0001, 0010, 0100, 1000) -> stack_full=1, count=4. Fifth push -> stack_err=1, count stays 4. Four pops restore 1000, 0100, 0010, 0001 in order, then stack_empty=1.
- Empty stack: pop with flag_load, mask=1111, zbus=0x0001, carries 0 -> stack_err=1, flags=0000 from the load, count=0. err_clr -> stack_err=0 next cycle.
- Count=2: push and pop same cycle -> count=2, flags unchanged, stack_err=1. Drive reset low between edges -> flags=0000, count=0, stack_err=0 immediately, without waiting for clk.
- Sweep cond 0-15 for flag patterns 0000, 1000, 0110, 0011, 1111 -> cond_true matches the cond map, including GT=0 and LE=1 when Z=1.
